// File: rtl/adex_pkg.sv
// Shared constants and types for the AdEx core scheduler: Q8.8 reset values,
// scheduler state encoding and the index-width helper.
package adex_pkg;

    localparam logic [15:0] ADEX_V_INIT = 16'hBF00;  // -65.0 mV in Q8.8
    localparam logic [15:0] ADEX_W_INIT = 16'h0000;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_WRITE = 2'd3
    } sched_state_t;

    // A single context still needs a 1-bit index port.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/adex_ctx_regfile.sv
// Per-neuron {V, w} context storage: one synchronous write port, two
// asynchronous read ports and a bulk reload to the initial word.
module adex_ctx_regfile
    import adex_pkg::*;
#(
    parameter int          NUM_NEURONS = 4,
    parameter int          IW          = idx_w(NUM_NEURONS),
    parameter logic [31:0] INIT_WORD   = {ADEX_V_INIT, ADEX_W_INIT}
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_init,
    input  logic          i_we,
    input  logic [IW-1:0] i_waddr,
    input  logic [31:0]   i_wdata,
    input  logic [IW-1:0] i_raddr_a,
    output logic [31:0]   o_rdata_a,
    input  logic [IW-1:0] i_raddr_b,
    output logic [31:0]   o_rdata_b
);

    localparam logic [IW:0] N_LIM = (IW+1)'(NUM_NEURONS);

    logic [31:0] r_mem [NUM_NEURONS];

    always_ff @(posedge clk) begin
        if (reset || i_init) begin
            for (int i = 0; i < NUM_NEURONS; i++) r_mem[i] <= INIT_WORD;
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Indices past the last context read as zero when NUM_NEURONS is not a power of two.
    assign o_rdata_a = ({1'b0, i_raddr_a} < N_LIM) ? r_mem[i_raddr_a] : 32'h0;
    assign o_rdata_b = ({1'b0, i_raddr_b} < N_LIM) ? r_mem[i_raddr_b] : 32'h0;

endmodule

// File: rtl/adex_core_scheduler.sv
// Time-multiplexes one AdEx update core over NUM_NEURONS contexts, one sweep per tick.
// Optional per-neuron saturating spike counters with `define ADEX_SPIKE_COUNT_EN.
module adex_core_scheduler
    import adex_pkg::*;
#(
    parameter int          NUM_NEURONS = 4,
    parameter int          TICK_DIV    = 1000,
    parameter int          WAIT_MAX    = 255,
    parameter logic [15:0] V_INIT      = ADEX_V_INIT,
    parameter logic [15:0] W_INIT      = ADEX_W_INIT,
    parameter int          IW          = idx_w(NUM_NEURONS)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   init,
    output logic                   core_start,
    output logic [IW-1:0]          core_nid,
    output logic [15:0]            core_v,
    output logic [15:0]            core_w,
    input  logic                   core_done,
    input  logic [15:0]            core_v_next,
    input  logic [15:0]            core_w_next,
    input  logic                   core_spike,
    output logic [NUM_NEURONS-1:0] spikes,
    output logic                   step_done,
    output logic [15:0]            step_cnt,
    output logic                   overrun,
    output logic                   core_err,
    input  logic [IW-1:0]          rd_idx,
    output logic [15:0]            rd_v,
    output logic [15:0]            rd_w,
`ifdef ADEX_SPIKE_COUNT_EN
    output logic [7:0]             rd_cnt,
`endif
    output logic [1:0]             dbg_state
);

    localparam int              TW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int              WW        = $clog2(WAIT_MAX + 1);
    localparam logic [TW-1:0]   TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [WW-1:0]   WAIT_LAST = WW'(WAIT_MAX - 1);
    localparam logic [IW-1:0]   NID_LAST  = IW'(NUM_NEURONS - 1);

    sched_state_t           r_state;
    logic [TW-1:0]          r_tick_cnt;
    logic [WW-1:0]          r_wait_cnt;
    logic [IW-1:0]          r_nid;
    logic [NUM_NEURONS-1:0] r_scratch;
    logic [NUM_NEURONS-1:0] r_spikes;
    logic [15:0]            r_res_v;
    logic [15:0]            r_res_w;
    logic                   r_res_spike;
    logic                   r_core_start;
    logic                   r_step_done;
    logic [15:0]            r_step_cnt;
    logic                   r_overrun;
    logic                   r_core_err;

    logic                   w_tick;
    logic                   w_ctx_init;
    logic                   w_ctx_we;
    logic [31:0]            w_ctx_cur;
    logic [31:0]            w_ctx_rd;
    logic [NUM_NEURONS-1:0] w_scratch_next;

    assign w_tick     = enable && (r_tick_cnt == TICK_LAST);
    assign w_ctx_init = init && (r_state == S_IDLE);
    assign w_ctx_we   = (r_state == S_WRITE);

    always_comb begin
        w_scratch_next        = r_scratch;
        w_scratch_next[r_nid] = r_res_spike;
    end

    always_ff @(posedge clk) begin
        if (reset || !enable || r_tick_cnt == TICK_LAST) r_tick_cnt <= '0;
        else                                             r_tick_cnt <= r_tick_cnt + 1'b1;
    end

    adex_ctx_regfile #(
        .NUM_NEURONS (NUM_NEURONS),
        .IW          (IW),
        .INIT_WORD   ({V_INIT, W_INIT})
    ) u_ctx (
        .clk       (clk),
        .reset     (reset),
        .i_init    (w_ctx_init),
        .i_we      (w_ctx_we),
        .i_waddr   (r_nid),
        .i_wdata   ({r_res_v, r_res_w}),
        .i_raddr_a (r_nid),
        .o_rdata_a (w_ctx_cur),
        .i_raddr_b (rd_idx),
        .o_rdata_b (w_ctx_rd)
    );

    // Core results are captured on core_done so the core need not hold them into S_WRITE.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_wait_cnt   <= '0;
            r_nid        <= '0;
            r_scratch    <= '0;
            r_spikes     <= '0;
            r_res_v      <= '0;
            r_res_w      <= '0;
            r_res_spike  <= 1'b0;
            r_core_start <= 1'b0;
            r_step_done  <= 1'b0;
            r_step_cnt   <= '0;
            r_overrun    <= 1'b0;
            r_core_err   <= 1'b0;
        end else begin
            r_core_start <= 1'b0;
            r_step_done  <= 1'b0;
            if (w_tick && r_state != S_IDLE) r_overrun <= 1'b1;
            case (r_state)
                S_IDLE: begin
                    if (!init && w_tick) begin
                        r_state      <= S_ISSUE;
                        r_nid        <= '0;
                        r_scratch    <= '0;
                        r_core_start <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    r_state    <= S_WAIT;
                    r_wait_cnt <= '0;
                end
                S_WAIT: begin
                    if (core_done) begin
                        r_state     <= S_WRITE;
                        r_res_v     <= core_v_next;
                        r_res_w     <= core_w_next;
                        r_res_spike <= core_spike;
                    end else if (r_wait_cnt == WAIT_LAST) begin
                        r_state    <= S_IDLE;
                        r_core_err <= 1'b1;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
                end
                S_WRITE: begin
                    r_scratch <= w_scratch_next;
                    if (r_nid == NID_LAST) begin
                        r_state     <= S_IDLE;
                        r_spikes    <= w_scratch_next;
                        r_step_done <= 1'b1;
                        r_step_cnt  <= r_step_cnt + 16'd1;
                    end else if (enable) begin
                        r_state      <= S_ISSUE;
                        r_nid        <= r_nid + 1'b1;
                        r_core_start <= 1'b1;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef ADEX_SPIKE_COUNT_EN
    localparam logic [IW:0] N_LIM = (IW+1)'(NUM_NEURONS);

    logic [7:0] r_spk_cnt [NUM_NEURONS];

    always_ff @(posedge clk) begin
        if (reset || w_ctx_init) begin
            for (int i = 0; i < NUM_NEURONS; i++) r_spk_cnt[i] <= 8'd0;
        end else if (w_ctx_we && r_res_spike && r_spk_cnt[r_nid] != 8'hFF) begin
            r_spk_cnt[r_nid] <= r_spk_cnt[r_nid] + 8'd1;
        end
    end

    assign rd_cnt = ({1'b0, rd_idx} < N_LIM) ? r_spk_cnt[rd_idx] : 8'd0;
`endif

    assign core_start = r_core_start;
    assign core_nid   = r_nid;
    assign core_v     = w_ctx_cur[31:16];
    assign core_w     = w_ctx_cur[15:0];
    assign spikes     = r_spikes;
    assign step_done  = r_step_done;
    assign step_cnt   = r_step_cnt;
    assign overrun    = r_overrun;
    assign core_err   = r_core_err;
    assign rd_v       = w_ctx_rd[31:16];
    assign rd_w       = w_ctx_rd[15:0];
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_adex_core_scheduler.sv
// Bench for adex_core_scheduler: transaction-level core responder, context/spike
// reference model, step scoreboard. Covers ADEX_SPIKE_COUNT_EN when defined.
module tb_adex_core_scheduler;
    import adex_pkg::*;

    localparam int N    = 4;
    localparam int TDIV = 20;
    localparam int WMAX = 30;

    logic          clk = 1'b0;
    logic          reset, enable, init;
    logic          core_start, core_done, core_spike;
    logic [1:0]    core_nid, rd_idx, dbg_state;
    logic [15:0]   core_v, core_w, core_v_next, core_w_next, rd_v, rd_w, step_cnt;
    logic [N-1:0]  spikes;
    logic          step_done, overrun, core_err;
`ifdef ADEX_SPIKE_COUNT_EN
    logic [7:0]    rd_cnt;
`endif

    always #5 clk = ~clk;

    adex_core_scheduler #(.NUM_NEURONS(N), .TICK_DIV(TDIV), .WAIT_MAX(WMAX)) dut (
        .clk(clk), .reset(reset), .enable(enable), .init(init),
        .core_start(core_start), .core_nid(core_nid), .core_v(core_v), .core_w(core_w),
        .core_done(core_done), .core_v_next(core_v_next), .core_w_next(core_w_next),
        .core_spike(core_spike), .spikes(spikes), .step_done(step_done), .step_cnt(step_cnt),
        .overrun(overrun), .core_err(core_err), .rd_idx(rd_idx), .rd_v(rd_v), .rd_w(rd_w),
`ifdef ADEX_SPIKE_COUNT_EN
        .rd_cnt(rd_cnt),
`endif
        .dbg_state(dbg_state)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: contexts, committed spikes, step count, saturating counts.
    logic [15:0]  m_v [N];
    logic [15:0]  m_w [N];
    int           m_cnt [N];
    logic [N-1:0] m_scratch, m_spikes;
    int           m_steps, next_nid, n_starts, last_start_nid, obs_steps;
    logic [N-1:0] exp_q [$];
    longint       cyc = 0;
    longint       last_sd = 0, prev_sd = 0;

    int           lat = 2;
    bit           never_done = 0;
    int           spike_mode = 0;
    logic [N-1:0] spike_mask = '0;

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_v[i] = ADEX_V_INIT; m_w[i] = ADEX_W_INIT; m_cnt[i] = 0;
        end
    endtask

    always @(posedge clk) cyc++;

    // Core responder: checks each issued context, answers after lat cycles.
    initial begin : responder
        int nid;
        logic spk;
        core_done = 0; core_v_next = '0; core_w_next = '0; core_spike = 0;
        forever begin
            @(negedge clk);
            if (core_start === 1'b1 && reset === 1'b0) begin
                nid = int'(core_nid);
                n_starts++;
                last_start_nid = nid;
                check("issue_nid", nid, next_nid);
                check("issue_v", core_v, m_v[nid]);
                check("issue_w", core_w, m_w[nid]);
                check("spikes_held", spikes, m_spikes);
                if (nid == 0) m_scratch = '0;
                if (!never_done) begin
                    repeat (lat) @(negedge clk);
                    case (spike_mode)
                        1:       spk = spike_mask[nid];
                        2:       spk = 1'($urandom_range(0, 1));
                        3:       spk = 1'b1;
                        default: spk = 1'b0;
                    endcase
                    core_v_next = (spike_mode == 2) ? 16'($urandom) : m_v[nid] + 16'h0100;
                    core_w_next = 16'($urandom);
                    core_spike  = spk;
                    core_done   = 1;
                    @(negedge clk);
                    core_done = 0;
                    m_v[nid] = core_v_next;
                    m_w[nid] = core_w_next;
                    m_scratch[nid] = spk;
                    if (spk && m_cnt[nid] < 255) m_cnt[nid]++;
                    if (nid == N - 1) begin
                        m_spikes = m_scratch;
                        exp_q.push_back(m_scratch);
                        m_steps++;
                        next_nid = 0;
                    end else if (!enable) begin
                        next_nid = 0;
                    end else begin
                        next_nid = nid + 1;
                    end
                end
            end
        end
    end

    // Step scoreboard: each step_done pops the expected committed spike vector.
    always @(negedge clk) begin
        if (reset === 1'b0 && step_done === 1'b1) begin
            obs_steps++;
            prev_sd = last_sd;
            last_sd = cyc;
            if (exp_q.size() == 0) check("step_unexpected", 1, 0);
            else                   check("spikes_commit", spikes, exp_q.pop_front());
            check("step_cnt", step_cnt, 16'(m_steps));
        end
    end

    task automatic do_reset();
        reset = 1; enable = 0; init = 0; rd_idx = 0;
        repeat (3) @(negedge clk);
        model_reset();
        m_spikes = '0; m_scratch = '0; m_steps = 0; next_nid = 0; obs_steps = 0;
        exp_q.delete();
        check("rst_start", core_start, 0);
        check("rst_spikes", spikes, 0);
        check("rst_step_done", step_done, 0);
        check("rst_step_cnt", step_cnt, 0);
        check("rst_overrun", overrun, 0);
        check("rst_core_err", core_err, 0);
        check("rst_state", dbg_state, S_IDLE);
        check("rst_rd_v", rd_v, 16'hBF00);
        reset = 0;
        @(negedge clk);
    endtask

    task automatic wait_steps(input int target, input int budget);
        int k = 0;
        while (obs_steps < target && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("step_wait_timeout", obs_steps >= target, 1);
    endtask

    task automatic check_contexts(input string tag);
        for (int i = 0; i < N; i++) begin
            rd_idx = 2'(i);
            #1;
            check({tag, "_v"}, rd_v, m_v[i]);
            check({tag, "_w"}, rd_w, m_w[i]);
        end
    endtask

    initial begin : watchdog
        #2_000_000;
        failures++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : main
        int base, steps_before, k;
        do_reset();

        // Two plain sweeps: every V advances by 256 per step.
        lat = 2; spike_mode = 0; enable = 1;
        wait_steps(2, 200);
        enable = 0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < N; i++) begin
            rd_idx = 2'(i);
            #1;
            check("sweep2_rd_v", rd_v, 16'hC100);
        end
        check("sweep2_step_cnt", step_cnt, 16'd2);
        check("sweep2_overrun", overrun, 0);

        // Only neuron 2 spikes.
        spike_mode = 1; spike_mask = 4'b0100; enable = 1;
        wait_steps(3, 200);
        enable = 0;
        @(negedge clk);
        check("mask_spikes", spikes, 4'b0100);

        // Randomised results and latencies short enough to avoid overrun.
        spike_mode = 2;
        for (int r = 0; r < 4; r++) begin
            lat = $urandom_range(1, 2);
            enable = 1;
            wait_steps(obs_steps + 2, 200);
            enable = 0;
            repeat (2) @(negedge clk);
        end
        check_contexts("rand_ctx");
        check("rand_overrun", overrun, 0);

        // Drop enable during the nid=1 transaction.
        lat = 2; spike_mode = 0; enable = 1; steps_before = m_steps;
        k = 0;
        while (!(core_start === 1'b1 && core_nid == 2'd1) && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("abort_saw_nid1", k < 200, 1);
        enable = 0;
        repeat (40) @(negedge clk);
        check("abort_last_nid", last_start_nid, 1);
        check("abort_state", dbg_state, S_IDLE);
        check("abort_step_cnt", step_cnt, 16'(steps_before));
        check_contexts("abort_ctx");
        init = 1;
        @(negedge clk);
        init = 0;
        model_reset();
        @(negedge clk);
        check_contexts("init_ctx");
        rd_idx = 2'd1;
        #1;
        check("init_rd_v1", rd_v, 16'hBF00);

        // Long core latency: sweeps outlast the tick period.
        lat = 10; enable = 1; base = obs_steps;
        wait_steps(base + 3, 600);
        enable = 0;
        check("slow_overrun", overrun, 1);
        check("slow_period", 32'(last_sd - prev_sd), TDIV * ((N * (lat + 2)) / TDIV + 1));
        repeat (5) @(negedge clk);

        // Core never answers: timeout, abandon the sweep, restart at nid 0.
        never_done = 1; next_nid = 0; steps_before = m_steps; enable = 1;
        k = 0;
        while (core_err !== 1'b1 && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("timeout_err", core_err, 1);
        check("timeout_state", dbg_state, S_IDLE);
        base = n_starts;
        k = 0;
        while (n_starts == base && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("timeout_restart", n_starts > base, 1);
        enable = 0;
        repeat (WMAX + 5) @(negedge clk);
        never_done = 0;
        check("timeout_step_cnt", step_cnt, 16'(steps_before));
        check("timeout_state_end", dbg_state, S_IDLE);

`ifdef ADEX_SPIKE_COUNT_EN
        // Spike on every update until the counters saturate.
        do_reset();
        lat = 1; spike_mode = 3; enable = 1;
        wait_steps(300, 300 * TDIV + 100);
        enable = 0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < N; i++) begin
            rd_idx = 2'(i);
            #1;
            check("cnt_sat", rd_cnt, 8'(m_cnt[i]));
            check("cnt_sat_255", rd_cnt, 8'd255);
        end
        init = 1;
        @(negedge clk);
        init = 0;
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            rd_idx = 2'(i);
            #1;
            check("cnt_init", rd_cnt, 8'd0);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
